// File: rtl/pipeline_combine_pkg.sv
// Shared constants for the lane-combining join stage.
// Holds default geometry for pipeline_combine and the RSA datapath lane count.
// Pure declarations; no logic, no latency, no flow control.
package pipeline_combine_pkg;

  // Default join geometry: two lanes of 32-bit payload, full-throughput ready.
  localparam int PC_DEFAULT_N          = 2;
  localparam int PC_DEFAULT_W          = 32;
  localparam int PC_DEFAULT_PASS_READY = 1;

  // Number of parallel Montgomery multipliers feeding the RSA combine stage.
  localparam int RSA_MONT_LANES = 4;

  // Width of the concatenated output bus for N lanes of W bits.
  function automatic int pc_out_width(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/pipeline_combine_capture_lane.sv
// One-beat capture register for a single lane of the join stage.
// Latency: data visible on 'data' / 'full' one cycle after the accept edge.
// Backpressure: i_ready low while holding a beat, unless the combined output fires this cycle and PASS_READY=1.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low (clears full; data is not reset)
//   i_valid  in   producer offers a beat
//   i_ready  out  lane accepts a beat this cycle
//   i_data   in   W-bit payload
//   fire     in   combined output is being consumed this cycle
//   full     out  lane holds a beat for the current transaction
//   data     out  captured payload (meaningful only while full=1)
module pipeline_capture_lane
  import pipeline_combine_pkg::*;
#(
  parameter int W          = PC_DEFAULT_W,
  parameter int PASS_READY = PC_DEFAULT_PASS_READY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  input  logic         fire,
  output logic         full,
  output logic [W-1:0] data
);

  localparam logic LP_PASS = (PASS_READY != 0);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_accept;

  // With pass-through ready the slot being vacated by 'fire' can be refilled
  // in the same cycle; this is the only combinational path from o_ready.
  assign i_ready  = !r_full || (LP_PASS && fire);
  assign w_accept = i_valid && i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
    end else if (fire) begin
      r_full <= 1'b0;
    end
  end

  // Payload register is deliberately not reset: it is only observed while full.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= i_data;
    end
  end

  assign full = r_full;
  assign data = r_data;

endmodule

// File: rtl/pipeline_combine.sv
// Joins N valid/ready lanes into one combined beat once every lane has delivered one beat.
// Latency: o_valid rises one cycle after the last lane's accept edge; o_valid/o_data come from registers only.
// Backpressure: o_data held stable until o_ready; full lanes stall their producers until the combined beat fires.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low; discards any partial transaction
//   i_valid  in   [N]      lane i offers a beat
//   i_ready  out  [N]      lane i accepts a beat this cycle
//   i_data   in   [N][W]   lane i payload
//   o_valid  out           combined beat available
//   o_ready  in            downstream accepts combined beat
//   o_data   out  [N*W]    {lane N-1 .. lane 0}, lane i at bits [i*W +: W]
module pipeline_combine
  import pipeline_combine_pkg::*;
#(
  parameter int N          = PC_DEFAULT_N,
  parameter int W          = PC_DEFAULT_W,
  parameter int PASS_READY = PC_DEFAULT_PASS_READY
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      i_valid,
  output logic [N-1:0]                      i_ready,
  input  logic [N-1:0][W-1:0]               i_data,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [pc_out_width(N, W)-1:0]     o_data
);

  logic [N-1:0]        w_full;
  logic [N-1:0][W-1:0] w_lane_data;
  logic                w_fire;

  // Combined beat exists only when every lane holds its beat for this transaction.
  assign o_valid = &w_full;
  assign w_fire  = o_valid && o_ready;

  for (genvar g = 0; g < N; g++) begin : g_lane
    pipeline_capture_lane #(
      .W          (W),
      .PASS_READY (PASS_READY)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid[g]),
      .i_ready (i_ready[g]),
      .i_data  (i_data[g]),
      .fire    (w_fire),
      .full    (w_full[g]),
      .data    (w_lane_data[g])
    );
  end

  // Packed lane array already has lane N-1 in the MSBs, matching the output layout.
  assign o_data = w_lane_data;

endmodule

// File: tb/tb_pipeline_combine.sv
module tb_pipeline_combine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Three configurations: 0 = N2 W8 pass-ready, 1 = N2 W8 registered ready, 2 = N4 W16 pass-ready
  int nl[3]  = '{2, 2, 4};
  int wl[3]  = '{8, 8, 16};
  int prl[3] = '{1, 0, 1};

  logic [1:0]       a_iv, a_ir;
  logic [1:0][7:0]  a_id;
  logic             a_ov, a_or;
  logic [15:0]      a_od;
  logic [1:0]       b_iv, b_ir;
  logic [1:0][7:0]  b_id;
  logic             b_ov, b_or;
  logic [15:0]      b_od;
  logic [3:0]       c_iv, c_ir;
  logic [3:0][15:0] c_id;
  logic             c_ov, c_or;
  logic [63:0]      c_od;

  pipeline_combine #(.N(2), .W(8), .PASS_READY(1)) u_a (
    .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir), .i_data(a_id),
    .o_valid(a_ov), .o_ready(a_or), .o_data(a_od));
  pipeline_combine #(.N(2), .W(8), .PASS_READY(0)) u_b (
    .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir), .i_data(b_id),
    .o_valid(b_ov), .o_ready(b_or), .o_data(b_od));
  pipeline_combine #(.N(4), .W(16), .PASS_READY(1)) u_c (
    .clk(clk), .rst(rst), .i_valid(c_iv), .i_ready(c_ir), .i_data(c_id),
    .o_valid(c_ov), .o_ready(c_or), .o_data(c_od));

  // ---------------- uniform access to the three instances ----------------
  function automatic logic [3:0] g_ir(input int k);
    case (k)
      0:       return {2'b00, a_ir};
      1:       return {2'b00, b_ir};
      default: return c_ir;
    endcase
  endfunction

  function automatic logic [3:0] g_iv(input int k);
    case (k)
      0:       return {2'b00, a_iv};
      1:       return {2'b00, b_iv};
      default: return c_iv;
    endcase
  endfunction

  function automatic logic [3:0][15:0] g_id(input int k);
    logic [3:0][15:0] r;
    r = '0;
    case (k)
      0: begin r[0] = {8'h00, a_id[0]}; r[1] = {8'h00, a_id[1]}; end
      1: begin r[0] = {8'h00, b_id[0]}; r[1] = {8'h00, b_id[1]}; end
      default: r = c_id;
    endcase
    return r;
  endfunction

  function automatic logic g_ov(input int k);
    case (k)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic logic g_or(input int k);
    case (k)
      0:       return a_or;
      1:       return b_or;
      default: return c_or;
    endcase
  endfunction

  function automatic logic [63:0] g_od(input int k);
    case (k)
      0:       return {48'h0, a_od};
      1:       return {48'h0, b_od};
      default: return c_od;
    endcase
  endfunction

  task automatic set_in(input int k, input logic [3:0] v, input logic [3:0][15:0] d, input logic ordy);
    case (k)
      0: begin a_iv = v[1:0]; a_id[0] = d[0][7:0]; a_id[1] = d[1][7:0]; a_or = ordy; end
      1: begin b_iv = v[1:0]; b_id[0] = d[0][7:0]; b_id[1] = d[1][7:0]; b_or = ordy; end
      default: begin c_iv = v; c_id = d; c_or = ordy; end
    endcase
  endtask

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each lane slot holds at most one pending beat; a combined beat exists when
  // every slot of the configuration is occupied.
  bit          mfull[3][4];
  logic [15:0] mdat[3][4];

  function automatic logic [15:0] lmask(input int k);
    return 16'hFFFF >> (16 - wl[k]);
  endfunction

  function automatic bit m_valid(input int k);
    bit r = 1'b1;
    for (int l = 0; l < nl[k]; l++) r &= mfull[k][l];
    return r;
  endfunction

  function automatic logic [3:0] m_ready(input int k, input logic ordy);
    logic [3:0] r = '0;
    bit consumed = m_valid(k) && ordy;
    for (int l = 0; l < nl[k]; l++) r[l] = !mfull[k][l] || (prl[k] != 0 && consumed);
    return r;
  endfunction

  function automatic logic [63:0] m_data(input int k);
    logic [63:0] r = '0;
    for (int l = 0; l < nl[k]; l++) r |= 64'(mdat[k][l] & lmask(k)) << (l * wl[k]);
    return r;
  endfunction

  // Scoreboard: the b-th combined beat must contain the b-th beat sent on every lane.
  int  gmode = 0;
  int  beat_cnt[3];
  int  fire_cyc[3][1024];
  bit  seqchk[3];

  function automatic logic [15:0] gen(input int l, input int b);
    logic [15:0] r;
    if (gmode == 0) r = 16'((l == 0 ? 0 : 128) + b + 1);
    else            r = {2'(l), 14'(b)};
    return r;
  endfunction

  // Compare on the falling edge; inputs are stable from here to the next rising
  // edge, so the model also advances here using exactly what the DUT will sample.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit          ev;
        logic [3:0]  er;
        logic [3:0]  iv;
        logic [3:0][15:0] id;
        if (!rst) for (int l = 0; l < 4; l++) mfull[k][l] = 1'b0;
        ev = m_valid(k);
        er = m_ready(k, g_or(k));
        check("o_valid", k, 64'(g_ov(k)), 64'(ev));
        check("i_ready", k, 64'(g_ir(k)), 64'(er));
        if (ev) check("o_data", k, g_od(k), m_data(k));
        if (rst && ev && g_or(k)) begin
          if (seqchk[k])
            for (int l = 0; l < nl[k]; l++)
              check("lane_seq", k, (g_od(k) >> (l * wl[k])) & 64'(lmask(k)),
                    64'(gen(l, beat_cnt[k]) & lmask(k)));
          if (beat_cnt[k] < 1024) fire_cyc[k][beat_cnt[k]] = cyc;
          beat_cnt[k]++;
        end
        if (rst) begin
          iv = g_iv(k);
          id = g_id(k);
          for (int l = 0; l < nl[k]; l++) begin
            if (iv[l] && er[l]) begin
              mfull[k][l] = 1'b1;
              mdat[k][l]  = id[l];
            end else if (ev && g_or(k)) begin
              mfull[k][l] = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int k, input int beats, input int vp, input int rp, input int budget);
    int sent[4];
    logic [3:0]       v;
    logic [3:0][15:0] d;
    logic [3:0]       r;
    int c = 0;
    for (int l = 0; l < 4; l++) sent[l] = 0;
    beat_cnt[k] = 0;
    seqchk[k]   = 1'b1;
    while (beat_cnt[k] < beats && c < budget) begin
      v = '0;
      d = '0;
      for (int l = 0; l < nl[k]; l++)
        if (sent[l] < beats && $urandom_range(0, 99) < vp) begin
          v[l] = 1'b1;
          d[l] = gen(l, sent[l]);
        end
      set_in(k, v, d, $urandom_range(0, 99) < rp);
      @(negedge clk);
      r = g_ir(k);
      for (int l = 0; l < nl[k]; l++) if (v[l] && r[l]) sent[l]++;
      step();
      c++;
    end
    set_in(k, '0, '0, 1'b0);
    seqchk[k] = 1'b0;
    checks++;
    if (beat_cnt[k] < beats) begin
      errors++;
      $display("FAIL stream_timeout dut%0d: got %0d beats expected %0d", k, beat_cnt[k], beats);
    end
  endtask

  logic [3:0][15:0] dz;

  initial begin
    rst = 1'b0;
    dz  = '0;
    for (int k = 0; k < 3; k++) begin
      set_in(k, '0, '0, 1'b0);
      beat_cnt[k] = 0;
      seqchk[k]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("reset_ir", 0, 64'(a_ir), 64'h3);
    check("reset_ov", 0, 64'(a_ov), 64'h0);

    // Reset while lane0 holds a beat
    dz = '0; dz[0] = 16'h0011;
    set_in(0, 4'b0001, dz, 1'b0);
    step();
    set_in(0, '0, '0, 1'b0);
    #1 check("lane0_full", 0, 64'(a_ir), 64'h2);
    rst = 1'b0;
    #1 check("rst_mid_ir", 0, 64'(a_ir), 64'h3);
    check("rst_mid_ov", 0, 64'(a_ov), 64'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_rel_ir", 0, 64'(a_ir), 64'h3);
    check("rst_rel_ov", 0, 64'(a_ov), 64'h0);

    // Skewed arrival: lane0 0xA5 at t0, lane1 0x3C at t3
    step();
    dz = '0; dz[0] = 16'h00A5;
    set_in(0, 4'b0001, dz, 1'b0);
    @(negedge clk);
    check("skew_t0_ir", 0, 64'(a_ir), 64'h3);
    for (int t = 1; t <= 3; t++) begin
      step();
      dz = '0; dz[1] = 16'h003C;
      set_in(0, (t == 3) ? 4'b0010 : 4'b0000, dz, 1'b0);
      @(negedge clk);
      check("skew_ir0_low", 0, 64'(a_ir[0]), 64'h0);
      check("skew_ov_low", 0, 64'(a_ov), 64'h0);
    end

    // Backpressure: output held with both lanes offering new data
    for (int t = 4; t <= 8; t++) begin
      step();
      dz = '0; dz[0] = 16'h0011; dz[1] = 16'h0022;
      set_in(0, 4'b0011, dz, 1'b0);
      @(negedge clk);
      check("bp_ov", 0, 64'(a_ov), 64'h1);
      check("bp_od", 0, 64'(a_od), 64'h3CA5);
      check("bp_ir", 0, 64'(a_ir), 64'h0);
    end
    step();
    set_in(0, 4'b0011, dz, 1'b1);
    @(negedge clk);
    check("fire_ir", 0, 64'(a_ir), 64'h3);
    check("fire_od", 0, 64'(a_od), 64'h3CA5);
    step();
    set_in(0, '0, '0, 1'b0);
    @(negedge clk);
    check("reload_ov", 0, 64'(a_ov), 64'h1);
    check("reload_od", 0, 64'(a_od), 64'h2211);
    step();
    set_in(0, '0, '0, 1'b1);
    step();
    set_in(0, '0, '0, 1'b0);
    step();

    // Streaming with pass-through ready: consecutive beats
    gmode = 0;
    run_stream(0, 8, 100, 100, 200);
    check("stream_a_beats", 0, 64'(beat_cnt[0]), 64'd8);
    for (int b = 1; b < 8; b++) check("stream_a_gap", 0, 64'(fire_cyc[0][b] - fire_cyc[0][b-1]), 64'd1);

    // Streaming with registered ready: one bubble per beat
    run_stream(1, 8, 100, 100, 200);
    check("stream_b_beats", 1, 64'(beat_cnt[1]), 64'd8);
    for (int b = 1; b < 8; b++) check("stream_b_gap", 1, 64'(fire_cyc[1][b] - fire_cyc[1][b-1]), 64'd2);

    // Random valid/ready on four 16-bit lanes
    gmode = 1;
    run_stream(2, 1000, 70, 60, 20000);
    check("rand_beats", 2, 64'(beat_cnt[2]), 64'd1000);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
